clkswitch_sched: RTL and testbench



---
 rtl/clkswitch_sched.sv | 162 ++++++++++++++++
 tb/tb_clkswitch_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkswitch_sched.sv
// HS/LS CPU clock switch scheduler: drives the switcher select inputs.
// Optional handshake timeout with sticky sw_err: `define SWITCH_TIMEOUT_EN.
module clkswitch_sched #(
  parameter int HOLDOFF_CYC = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       cpuclk_r,
  input  logic       rst_b,
  input  logic       slow_req,
  input  logic       hsclk_selected,
  input  logic       lsclk_selected,
  input  logic       cfg_wr,
  input  logic [2:0] cfg_wdata,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       cpu_rdy,
  output logic [2:0] sched_state,
  output logic [7:0] switch_cnt,
  output logic       sw_err
);

  localparam int HW = (HOLDOFF_CYC > 0) ?
                      $clog2(HOLDOFF_CYC + 1) : 1;

  typedef enum logic [2:0] {
    LS_RUN  = 3'd0,
    HOLDOFF = 3'd1,
    REQ_HS  = 3'd2,
    HS_RUN  = 3'd3,
    REQ_LS  = 3'd4
  } st_t;

  st_t           state;
  st_t           state_nxt;
  logic          hs_en;
  logic [1:0]    div_pending;
  logic [HW-1:0] ho_cnt;
  logic          to_hit;

  assign sched_state = state;

`ifdef SWITCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt;
  logic          wait_ack;

  // A handshake is outstanding while the matching ack is absent
  always_comb begin
    wait_ack = ((state == REQ_HS) && !hsclk_selected) ||
               ((state == REQ_LS) && !lsclk_selected);
  end

  assign to_hit = wait_ack &&
                  (to_cnt == TW'(TIMEOUT_CYC - 1));

  // Handshake age, restarted on every state change
  always_ff @(posedge cpuclk_r or negedge rst_b) begin
    if (!rst_b)                  to_cnt <= '0;
    else if (state_nxt != state) to_cnt <= '0;
    else if (wait_ack)           to_cnt <= to_cnt + 1'b1;
  end

  // Sticky timeout flag, cleared by the next config write
  always_ff @(posedge cpuclk_r or negedge rst_b) begin
    if (!rst_b)      sw_err <= 1'b0;
    else if (to_hit) sw_err <= 1'b1;
    else if (cfg_wr) sw_err <= 1'b0;
  end
`else
  assign to_hit = 1'b0;
  assign sw_err = 1'b0;
`endif

  // State register
  always_ff @(posedge cpuclk_r or negedge rst_b) begin
    if (!rst_b) state <= LS_RUN;
    else        state <= state_nxt;
  end

  // Next-state decode; handshakes are never aborted
  always_comb begin
    state_nxt = state;
    unique case (state)
      LS_RUN:
        if (hs_en && !slow_req) state_nxt = HOLDOFF;
      HOLDOFF:
        if (slow_req)          state_nxt = HOLDOFF;
        else if (!hs_en)       state_nxt = LS_RUN;
        else if (ho_cnt == '0) state_nxt = REQ_HS;
      REQ_HS:
        if (hsclk_selected) state_nxt = HS_RUN;
      HS_RUN:
        if (slow_req || !hs_en) state_nxt = REQ_LS;
      REQ_LS:
        if (lsclk_selected) state_nxt = LS_RUN;
      default:
        state_nxt = LS_RUN;
    endcase
    if (to_hit) state_nxt = LS_RUN;
  end

  // Switcher select and CPU stall from current state
  always_comb begin
    hsclk_sel = 1'b0;
    cpu_rdy   = 1'b1;
    unique case (state)
      REQ_HS: begin
        hsclk_sel = 1'b1;
        cpu_rdy   = 1'b0;
      end
      HS_RUN: begin
        hsclk_sel = 1'b1;
        cpu_rdy   = !slow_req;
      end
      REQ_LS: cpu_rdy = 1'b0;
      default: ;
    endcase
  end

  // Anti-thrash holdoff: reload on host access, else count down
  always_ff @(posedge cpuclk_r or negedge rst_b) begin
    if (!rst_b)
      ho_cnt <= HW'(HOLDOFF_CYC);
    else if (state != HOLDOFF || slow_req)
      ho_cnt <= HW'(HOLDOFF_CYC);
    else if (ho_cnt != '0)
      ho_cnt <= ho_cnt - 1'b1;
  end

  // Config capture; a timeout drops back to LS-only operation
  always_ff @(posedge cpuclk_r or negedge rst_b) begin
    if (!rst_b) begin
      hs_en       <= 1'b0;
      div_pending <= 2'b11;
    end else begin
      if (cfg_wr) begin
        hs_en       <= cfg_wdata[2];
        div_pending <= cfg_wdata[1:0];
      end
      if (to_hit) hs_en <= 1'b0;
    end
  end

  // Divider only changes while the HS clock is not driving the CPU
  always_ff @(posedge cpuclk_r or negedge rst_b) begin
    if (!rst_b)
      cpuclk_div_sel <= 2'b11;
    else if ((state == LS_RUN || state == HOLDOFF) &&
             !hsclk_selected)
      cpuclk_div_sel <= div_pending;
  end

  // Completed LS->HS transitions, wrapping
  always_ff @(posedge cpuclk_r or negedge rst_b) begin
    if (!rst_b)
      switch_cnt <= 8'd0;
    else if (state == REQ_HS && hsclk_selected)
      switch_cnt <= switch_cnt + 8'd1;
  end

endmodule

// File: tb/tb_clkswitch_sched.sv
// Directed bench for clkswitch_sched with an expectation queue.
// Timeout steps run when SWITCH_TIMEOUT_EN is defined.
module tb_clkswitch_sched;

  logic       cpuclk_r = 1'b0;
  logic       rst_b;
  logic       slow_req;
  logic       hsclk_selected;
  logic       lsclk_selected;
  logic       cfg_wr;
  logic [2:0] cfg_wdata;
  logic       hsclk_sel;
  logic [1:0] cpuclk_div_sel;
  logic       cpu_rdy;
  logic [2:0] sched_state;
  logic [7:0] switch_cnt;
  logic       sw_err;

  clkswitch_sched #(
    .HOLDOFF_CYC(4),
    .TIMEOUT_CYC(64)
  ) dut (
    .cpuclk_r       (cpuclk_r),
    .rst_b          (rst_b),
    .slow_req       (slow_req),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .cfg_wr         (cfg_wr),
    .cfg_wdata      (cfg_wdata),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .cpu_rdy        (cpu_rdy),
    .sched_state    (sched_state),
    .switch_cnt     (switch_cnt),
    .sw_err         (sw_err)
  );

  always #5 cpuclk_r = ~cpuclk_r;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       hs;
    logic [1:0] div;
    logic       rdy;
    logic [7:0] cnt;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [1:0] exp_div = 2'b11;
  logic [7:0] exp_cnt = 8'd0;
  logic       exp_err = 1'b0;

  task automatic clk1();
    @(posedge cpuclk_r);
    #2;
  endtask

  task automatic expect_st(string tag, logic [2:0] st,
                           logic hs, logic rdy);
    exp_t e;
    exp_t g;
    e.tag = tag;
    e.st  = st;
    e.hs  = hs;
    e.div = exp_div;
    e.rdy = rdy;
    e.cnt = exp_cnt;
    e.err = exp_err;
    q.push_back(e);
    #1;
    g = q.pop_front();
    n_chk++;
    assert ({sched_state, hsclk_sel, cpuclk_div_sel, cpu_rdy,
             switch_cnt, sw_err} ===
            {g.st, g.hs, g.div, g.rdy, g.cnt, g.err})
    else begin
      n_fail++;
      $error("FAIL %s: observed st=%0d hs=%0b div=%0d rdy=%0b cnt=%0d err=%0b, expected st=%0d hs=%0b div=%0d rdy=%0b cnt=%0d err=%0b",
             g.tag, sched_state, hsclk_sel, cpuclk_div_sel,
             cpu_rdy, switch_cnt, sw_err, g.st, g.hs, g.div,
             g.rdy, g.cnt, g.err);
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic wait_st(string tag, logic [2:0] st, int maxc);
    int k = 0;
    while (sched_state !== st && k < maxc) begin
      clk1();
      k++;
    end
    chk(tag, int'(sched_state), int'(st));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b          = 1'b1;
    slow_req       = 1'b0;
    hsclk_selected = 1'b0;
    lsclk_selected = 1'b1;
    cfg_wr         = 1'b0;
    cfg_wdata      = 3'b000;
    #1 rst_b = 1'b0;
    #2;
    expect_st("reset", 3'd0, 1'b0, 1'b1);
    @(negedge cpuclk_r);
    rst_b = 1'b1;

    for (int i = 0; i < 20; i++) begin
      clk1();
      expect_st("idle", 3'd0, 1'b0, 1'b1);
    end

    cfg_wr    = 1'b1;
    cfg_wdata = 3'b101;
    clk1();
    cfg_wr = 1'b0;
    expect_st("cfg_edge", 3'd0, 1'b0, 1'b1);
    clk1();
    exp_div = 2'b01;
    expect_st("ho_entry", 3'd1, 1'b0, 1'b1);
    lsclk_selected = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clk1();
      expect_st("ho_wait", 3'd1, 1'b0, 1'b1);
    end
    clk1();
    expect_st("req_hs1", 3'd2, 1'b1, 1'b0);
    clk1();
    expect_st("req_hs2", 3'd2, 1'b1, 1'b0);
    clk1();
    hsclk_selected = 1'b1;
    expect_st("req_hs3", 3'd2, 1'b1, 1'b0);
    clk1();
    exp_cnt = 8'd1;
    expect_st("hs_run", 3'd3, 1'b1, 1'b1);

    clk1();
    expect_st("hs_stay", 3'd3, 1'b1, 1'b1);
    slow_req = 1'b1;
    expect_st("hs_slow_rdy", 3'd3, 1'b1, 1'b0);
    clk1();
    slow_req       = 1'b0;
    hsclk_selected = 1'b0;
    expect_st("req_ls", 3'd4, 1'b0, 1'b0);
    clk1();
    expect_st("req_ls_wait", 3'd4, 1'b0, 1'b0);
    lsclk_selected = 1'b1;
    clk1();
    expect_st("ls_back", 3'd0, 1'b0, 1'b1);

    clk1();
    expect_st("ho_again", 3'd1, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      slow_req = (i % 3 == 2);
      clk1();
      expect_st("ho_reload", 3'd1, 1'b0, 1'b1);
    end
    slow_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clk1();
      expect_st("ho_count", 3'd1, 1'b0, 1'b1);
    end
    clk1();
    expect_st("ho_done", 3'd2, 1'b1, 1'b0);

    lsclk_selected = 1'b0;
    hsclk_selected = 1'b1;
    clk1();
    exp_cnt = 8'd2;
    expect_st("hs_run2", 3'd3, 1'b1, 1'b1);
    cfg_wr    = 1'b1;
    cfg_wdata = 3'b100;
    clk1();
    cfg_wr = 1'b0;
    expect_st("div_hold", 3'd3, 1'b1, 1'b1);
    slow_req = 1'b1;
    clk1();
    slow_req       = 1'b0;
    hsclk_selected = 1'b0;
    lsclk_selected = 1'b1;
    expect_st("req_ls2", 3'd4, 1'b0, 1'b0);
    clk1();
    expect_st("ls_div_hold", 3'd0, 1'b0, 1'b1);
    clk1();
    exp_div = 2'b00;
    expect_st("div_load", 3'd1, 1'b0, 1'b1);

    lsclk_selected = 1'b0;
    wait_st("to_req_hs", 3'd2, 8);
    slow_req = 1'b1;
    clk1();
    expect_st("req_hs_noack", 3'd2, 1'b1, 1'b0);
    hsclk_selected = 1'b1;
    clk1();
    exp_cnt = 8'd3;
    expect_st("hs_no_abort", 3'd3, 1'b1, 1'b0);
    clk1();
    slow_req       = 1'b0;
    hsclk_selected = 1'b0;
    lsclk_selected = 1'b1;
    expect_st("ls_after_hs", 3'd4, 1'b0, 1'b0);
    clk1();
    expect_st("ls_back2", 3'd0, 1'b0, 1'b1);

    lsclk_selected = 1'b0;
    hsclk_selected = 1'b1;
    wait_st("to_hs3", 3'd3, 12);
    exp_cnt = 8'd4;
    expect_st("hs_run3", 3'd3, 1'b1, 1'b1);
    cfg_wr    = 1'b1;
    cfg_wdata = 3'b000;
    slow_req  = 1'b1;
    clk1();
    cfg_wr   = 1'b0;
    slow_req = 1'b0;
    expect_st("both_req_ls", 3'd4, 1'b0, 1'b0);
    clk1();
    expect_st("single_req_ls", 3'd4, 1'b0, 1'b0);
    hsclk_selected = 1'b0;
    lsclk_selected = 1'b1;
    clk1();
    expect_st("ls_hs_off", 3'd0, 1'b0, 1'b1);
    clk1();
    expect_st("ls_stays", 3'd0, 1'b0, 1'b1);

    cfg_wr    = 1'b1;
    cfg_wdata = 3'b101;
    clk1();
    cfg_wr = 1'b0;
    for (int t = 0; t < 252; t++) begin
      lsclk_selected = 1'b0;
      hsclk_selected = 1'b1;
      wait_st("trip_hs", 3'd3, 12);
      exp_cnt = exp_cnt + 8'd1;
      slow_req = 1'b1;
      clk1();
      slow_req       = 1'b0;
      hsclk_selected = 1'b0;
      if (t < 251) begin
        lsclk_selected = 1'b1;
        clk1();
      end
    end
    chk("wrap_cnt", int'(switch_cnt), int'(exp_cnt));
    chk("in_req_ls", int'(sched_state), 4);

    slow_req = 1'b1;
    rst_b    = 1'b0;
    exp_cnt  = 8'd0;
    exp_div  = 2'b11;
    expect_st("async_reset", 3'd0, 1'b0, 1'b1);
    slow_req = 1'b0;

`ifdef SWITCH_TIMEOUT_EN
    @(negedge cpuclk_r);
    rst_b          = 1'b1;
    hsclk_selected = 1'b0;
    lsclk_selected = 1'b0;
    cfg_wr         = 1'b1;
    cfg_wdata      = 3'b101;
    clk1();
    cfg_wr = 1'b0;
    wait_st("to_req", 3'd2, 10);
    exp_div = 2'b01;
    for (int i = 1; i < 64; i++) begin
      clk1();
      expect_st("to_wait", 3'd2, 1'b1, 1'b0);
    end
    clk1();
    exp_err = 1'b1;
    expect_st("timeout", 3'd0, 1'b0, 1'b1);
    clk1();
    expect_st("hs_en_cleared", 3'd0, 1'b0, 1'b1);
    cfg_wr    = 1'b1;
    cfg_wdata = 3'b000;
    clk1();
    cfg_wr  = 1'b0;
    exp_err = 1'b0;
    expect_st("err_clear", 3'd0, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
